// File: rtl/bit_serial_addsub_ctrl.sv
// rtl/bit_serial_addsub_ctrl.sv - bit-serial two's-complement add/subtract sequencer around one full adder
//
// Ports:
//   CLK        rising-edge clock
//   R          asynchronous active-low reset
//   IN_VALID   A, B and SUB are valid
//   IN_READY   idle, operands can be accepted
//   A, B       WIDTH-bit operands
//   SUB        0: A+B, 1: A-B
//   OUT_VALID  SUM/COUT/OVF valid
//   OUT_READY  consumer takes the result
//   SUM        WIDTH-bit result
//   COUT       carry out of the MSB (inverted borrow when subtracting)
//   OVF        signed overflow
//   BUSY       an operation is in progress or awaiting hand-off
module bit_serial_addsub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SUB,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF,
    output logic             BUSY
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             sub_q;
    logic             carry;
    logic             cout_q;
    logic             ovf_q;

    logic             accept;
    logic             last_bit;
    logic             fa_a;
    logic             fa_b;
    logic             ys;
    logic             yc;

    // The single shared full adder. Subtraction inverts B here and seeds
    // the carry with 1 at load time, giving A + ~B + 1.
    always_comb begin
        fa_a = a_sh[0];
        fa_b = b_sh[0] ^ sub_q;
        ys   = fa_a ^ fa_b ^ carry;
        yc   = (fa_a & fa_b) | (carry & (fa_a ^ fa_b));
    end

    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (IN_VALID) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (OUT_READY) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            cnt    <= '0;
            sub_q  <= 1'b0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            a_sh  <= A;
            b_sh  <= B;
            sub_q <= SUB;
            carry <= SUB;
            cnt   <= '0;
        end else if (state == RUN) begin
            carry <= yc;
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            res   <= {ys, res[WIDTH-1:1]};
            // Leaving RUN on the last bit, so cnt never wraps.
            if (last_bit) begin
                ovf_q  <= carry ^ yc;
                cout_q <= yc;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // All handshake outputs decode the state register only, so there is no
    // combinational path from IN_VALID or OUT_READY.
    assign IN_READY  = (state == IDLE);
    assign OUT_VALID = (state == DONE);
    assign BUSY      = (state != IDLE);
    assign SUM       = res;
    assign COUT      = cout_q;
    assign OVF       = ovf_q;

endmodule

// File: tb/tb_bit_serial_addsub_ctrl.sv
// tb/tb_bit_serial_addsub_ctrl.sv - self-checking bench for bit_serial_addsub_ctrl
module tb_bit_serial_addsub_ctrl;

    logic       CLK = 1'b0;
    logic       R;
    always #5 CLK = ~CLK;

    logic       in_valid, in_ready, sub, out_valid, out_ready, cout, ovf, busy;
    logic [7:0] a, b, sum;

    logic       in_valid4, in_ready4, sub4, out_valid4, out_ready4, cout4, ovf4, busy4;
    logic [3:0] a4, b4, sum4;

    bit_serial_addsub_ctrl #(.WIDTH(8)) dut8 (
        .CLK(CLK), .R(R),
        .IN_VALID(in_valid), .IN_READY(in_ready),
        .A(a), .B(b), .SUB(sub),
        .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .SUM(sum), .COUT(cout), .OVF(ovf), .BUSY(busy)
    );

    bit_serial_addsub_ctrl #(.WIDTH(4)) dut4 (
        .CLK(CLK), .R(R),
        .IN_VALID(in_valid4), .IN_READY(in_ready4),
        .A(a4), .B(b4), .SUB(sub4),
        .OUT_VALID(out_valid4), .OUT_READY(out_ready4),
        .SUM(sum4), .COUT(cout4), .OVF(ovf4), .BUSY(busy4)
    );

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic exp_t model(input int w, input logic [31:0] a_in,
                                   input logic [31:0] b_in, input logic s);
        logic [63:0] mask, aa, bb, full;
        exp_t        e;
        mask   = (64'd1 << w) - 64'd1;
        aa     = {32'd0, a_in} & mask;
        bb     = (s ? ~{32'd0, b_in} : {32'd0, b_in}) & mask;
        full   = aa + bb + {63'd0, s};
        e.sum  = 32'(full & mask);
        e.cout = full[w];
        e.ovf  = (aa[w-1] == bb[w-1]) && (e.sum[w-1] != aa[w-1]);
        return e;
    endfunction

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    // Starts in IDLE one time unit after an edge; returns with dut8 in DONE.
    task automatic run_op8(input logic [7:0] ai, input logic [7:0] bi, input logic si,
                           output int lat, output logic [7:0] s_o,
                           output logic c_o, output logic o_o);
        int n;
        a = ai; b = bi; sub = si; in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            step;
            n++;
        end
        lat = n; s_o = sum; c_o = cout; o_o = ovf;
    endtask

    task automatic test_reset;
        R = 1'b0;
        step;
        step;
        n_checks++; if (sum !== 8'h00)     begin n_fail++; $display("FAIL reset_sum: got %h want 00", sum); end
        n_checks++; if (cout !== 1'b0)     begin n_fail++; $display("FAIL reset_cout: got %b want 0", cout); end
        n_checks++; if (ovf !== 1'b0)      begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        R = 1'b1;
        step;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_directed;
        logic [7:0] ta[5], tb_[5], ts[5];
        logic       tsub[5], tc[5], to[5];
        int         lat;
        logic [7:0] s_o;
        logic       c_o, o_o;
        exp_t       e;
        ta[0] = 8'h5A; tb_[0] = 8'h3C; tsub[0] = 1'b0; ts[0] = 8'h96; tc[0] = 1'b0; to[0] = 1'b1;
        ta[1] = 8'hFF; tb_[1] = 8'h01; tsub[1] = 1'b0; ts[1] = 8'h00; tc[1] = 1'b1; to[1] = 1'b0;
        ta[2] = 8'h10; tb_[2] = 8'h20; tsub[2] = 1'b1; ts[2] = 8'hF0; tc[2] = 1'b0; to[2] = 1'b0;
        ta[3] = 8'h80; tb_[3] = 8'h01; tsub[3] = 1'b1; ts[3] = 8'h7F; tc[3] = 1'b1; to[3] = 1'b1;
        ta[4] = 8'h00; tb_[4] = 8'h00; tsub[4] = 1'b1; ts[4] = 8'h00; tc[4] = 1'b1; to[4] = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            e.sum = {24'd0, ts[i]}; e.cout = tc[i]; e.ovf = to[i];
            sb.push_back(e);
            run_op8(ta[i], tb_[i], tsub[i], lat, s_o, c_o, o_o);
            e = sb.pop_front();
            n_checks++; if (lat != 8)         begin n_fail++; $display("FAIL directed%0d_latency: got %0d want 8", i, lat); end
            n_checks++; if (s_o !== e.sum[7:0]) begin n_fail++; $display("FAIL directed%0d_sum: got %h want %h", i, s_o, e.sum[7:0]); end
            n_checks++; if (c_o !== e.cout)   begin n_fail++; $display("FAIL directed%0d_cout: got %b want %b", i, c_o, e.cout); end
            n_checks++; if (o_o !== e.ovf)    begin n_fail++; $display("FAIL directed%0d_ovf: got %b want %b", i, o_o, e.ovf); end
            step;
        end
    endtask

    task automatic test_backpressure;
        int         lat;
        logic [7:0] s_o;
        logic       c_o, o_o;
        exp_t       e;
        out_ready = 1'b0;
        sb.push_back(model(8, 32'h7F, 32'h01, 1'b0));
        run_op8(8'h7F, 8'h01, 1'b0, lat, s_o, c_o, o_o);
        e = sb.pop_front();
        n_checks++; if (lat != 8)           begin n_fail++; $display("FAIL bp_latency: got %0d want 8", lat); end
        n_checks++; if (s_o !== e.sum[7:0]) begin n_fail++; $display("FAIL bp_sum: got %h want %h", s_o, e.sum[7:0]); end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
            step;
            n_checks++; if (out_valid !== 1'b1)  begin n_fail++; $display("FAIL bp_hold_valid%0d: got %b want 1", i, out_valid); end
            n_checks++; if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL bp_in_ready%0d: got %b want 0", i, in_ready); end
            n_checks++; if (sum !== e.sum[7:0])  begin n_fail++; $display("FAIL bp_sum_stable%0d: got %h want %h", i, sum, e.sum[7:0]); end
            n_checks++; if (cout !== e.cout)     begin n_fail++; $display("FAIL bp_cout_stable%0d: got %b want %b", i, cout, e.cout); end
            n_checks++; if (ovf !== e.ovf)       begin n_fail++; $display("FAIL bp_ovf_stable%0d: got %b want %b", i, ovf, e.ovf); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
        n_checks++; if (sum !== e.sum[7:0]) begin n_fail++; $display("FAIL bp_release_sum: got %h want %h", sum, e.sum[7:0]); end
        step;
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL bp_no_latch_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_run;
        int         lat, seen;
        logic [7:0] s_o;
        logic       c_o, o_o;
        exp_t       e;
        out_ready = 1'b1;
        a = 8'h55; b = 8'h11; sub = 1'b0; in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        step; step; step;
        R = 1'b0;
        #1;
        n_checks++; if (sum !== 8'h00)      begin n_fail++; $display("FAIL midrst_sum: got %h want 00", sum); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        step;
        R = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step;
            if (out_valid === 1'b1) seen++;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL midrst_no_output: got %0d pulses want 0", seen); end
        e.sum = 32'h03; e.cout = 1'b0; e.ovf = 1'b0;
        sb.push_back(e);
        run_op8(8'h01, 8'h02, 1'b0, lat, s_o, c_o, o_o);
        e = sb.pop_front();
        n_checks++; if (lat != 8)           begin n_fail++; $display("FAIL midrst_latency: got %0d want 8", lat); end
        n_checks++; if (s_o !== e.sum[7:0]) begin n_fail++; $display("FAIL midrst_sum_after: got %h want %h", s_o, e.sum[7:0]); end
        n_checks++; if (c_o !== e.cout)     begin n_fail++; $display("FAIL midrst_cout_after: got %b want %b", c_o, e.cout); end
        step;
    endtask

    task automatic test_back_to_back;
        int   issued, got, last_t, cyc;
        exp_t e;
        issued = 0; got = 0; last_t = -1; cyc = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while (got < 4 && cyc < 120) begin
            if (out_valid === 1'b1) begin
                if (sb.size() > 0) e = sb.pop_front();
                n_checks++; if (sum !== e.sum[7:0]) begin n_fail++; $display("FAIL b2b%0d_sum: got %h want %h", got, sum, e.sum[7:0]); end
                n_checks++; if (cout !== e.cout)    begin n_fail++; $display("FAIL b2b%0d_cout: got %b want %b", got, cout, e.cout); end
                n_checks++; if (ovf !== e.ovf)      begin n_fail++; $display("FAIL b2b%0d_ovf: got %b want %b", got, ovf, e.ovf); end
                if (last_t >= 0) begin
                    n_checks++; if (cyc - last_t != 10) begin n_fail++; $display("FAIL b2b%0d_spacing: got %0d want 10", got, cyc - last_t); end
                end
                last_t = cyc;
                got++;
            end
            if (in_ready === 1'b1 && issued < 4) begin
                a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
                in_valid = 1'b1;
                sb.push_back(model(8, {24'd0, a}, {24'd0, b}, sub));
                issued++;
            end else if (issued >= 4) begin
                in_valid = 1'b0;
            end
            step;
            cyc++;
        end
        in_valid = 1'b0;
        n_checks++; if (got != 4) begin n_fail++; $display("FAIL b2b_count: got %0d results want 4", got); end
        sb.delete();
        step;
    endtask

    task automatic test_exhaustive4;
        int   n;
        exp_t e;
        out_ready4 = 1'b1;
        for (int s = 0; s < 2; s++) begin
            for (int ai = 0; ai < 16; ai++) begin
                for (int bi = 0; bi < 16; bi++) begin
                    a4 = 4'(ai); b4 = 4'(bi); sub4 = 1'(s); in_valid4 = 1'b1;
                    sb.push_back(model(4, 32'(ai), 32'(bi), 1'(s)));
                    step;
                    in_valid4 = 1'b0;
                    n = 0;
                    while (out_valid4 !== 1'b1 && n < 20) begin
                        step;
                        n++;
                    end
                    e = sb.pop_front();
                    n_checks++; if (n != 4)               begin n_fail++; $display("FAIL w4_latency a=%h b=%h sub=%0d: got %0d want 4", ai, bi, s, n); end
                    n_checks++; if (sum4 !== e.sum[3:0])  begin n_fail++; $display("FAIL w4_sum a=%h b=%h sub=%0d: got %h want %h", ai, bi, s, sum4, e.sum[3:0]); end
                    n_checks++; if (cout4 !== e.cout)     begin n_fail++; $display("FAIL w4_cout a=%h b=%h sub=%0d: got %b want %b", ai, bi, s, cout4, e.cout); end
                    n_checks++; if (ovf4 !== e.ovf)       begin n_fail++; $display("FAIL w4_ovf a=%h b=%h sub=%0d: got %b want %b", ai, bi, s, ovf4, e.ovf); end
                    step;
                end
            end
        end
    endtask

    initial begin
        R = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
        in_valid4 = 1'b0; out_ready4 = 1'b1; a4 = '0; b4 = '0; sub4 = 1'b0;
        test_reset;
        test_directed;
        test_backpressure;
        test_reset_mid_run;
        test_back_to_back;
        test_exhaustive4;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
